captura_operandos: RTL and testbench
====================================

CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable samples required to accept a button level change (10 ms at 100 MHz).
REQ-003 Parameter SYNC_STAGES, default 2, flip-flop depth of the button synchroniser (legal range 2..4).
REQ-004 CLK100MHZ  input  1  single system clock, 100 MHz.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 A  input  WIDTH  multiplicand switches, asynchronous, level.
REQ-007 B  input  WIDTH  multiplier switches, asynchronous, level.
REQ-008 pb_entrada  input  1  raw capture pushbutton, asynchronous, bouncing.
REQ-009 ready_in  input  1  downstream multiplier accepts the operand pair.
REQ-010 multiplicando  output  WIDTH  latched A.
REQ-011 multiplicador  output  WIDTH  latched B.
REQ-012 valid_out  output  1  latched operand pair is pending.
REQ-013 pushbutton_salida  output  1  one-cycle pulse per accepted press.
REQ-014 LED  output  2*WIDTH  live mirror {A, B}, registered once.
REQ-015 LED_reset  output  1  high while reset is asserted.
REQ-016 LED_pb  output  1  debounced button level.
REQ-017 dropped  output  1  sticky flag: a press arrived while valid_out was high.

Function
REQ-018 pb_entrada SHALL pass through SYNC_STAGES flip-flops before any other use.
REQ-019 Debouncer SHALL change LED_pb only after the synchronised input differs from LED_pb for DEBOUNCE_CYCLES consecutive cycles; any matching sample clears the counter.
REQ-020 pushbutton_salida SHALL be high for exactly one cycle, the cycle after LED_pb goes 0->1; a 1->0 change produces no pulse.
REQ-021 Latency: a clean rising edge on pb_entrada first sampled at edge e SHALL produce pushbutton_salida high in cycle e+SYNC_STAGES+DEBOUNCE_CYCLES+1.
REQ-022 FSM states: IDLE, HOLD.
- IDLE: on pushbutton_salida, latch A->multiplicando and B->multiplicador, assert valid_out on the next cycle, go to HOLD.
- HOLD: valid_out high, operands stable; on valid_out & ready_in return to IDLE with valid_out low on the next cycle.
REQ-023 A pulse arriving in HOLD SHALL NOT alter the operands; it SHALL set dropped, which clears only on reset.
REQ-024 If a pulse and the handshake completion occur in the same HOLD cycle, the handshake SHALL complete, the pulse SHALL be dropped, and dropped SHALL be set.
REQ-025 ready_in in IDLE SHALL be ignored.
REQ-026 multiplicando and multiplicador SHALL hold their values from one capture to the next; switch changes outside a capture SHALL only affect LED.
REQ-027 LED SHALL equal {A, B} delayed by one cycle.

Reset
REQ-028 While reset is high at a clock edge: state IDLE, multiplicando 0, multiplicador 0, valid_out 0, pushbutton_salida 0, LED 0, LED_pb 0, dropped 0, debounce counter 0, synchroniser 0.
REQ-029 Reset asserted in HOLD SHALL abandon the pending pair with no handshake; LED_reset SHALL equal reset combinationally.
REQ-030 A button held through reset deassertion SHALL produce a pulse after the full REQ-021 latency, counted from the first post-reset edge.

Structure
REQ-031 Package captura_pkg SHALL hold the state enum (IDLE, HOLD) and the default parameter constants.
REQ-032 Synchroniser and debouncer SHALL be one sub-module, antirrebote (parameters SYNC_STAGES and DEBOUNCE_CYCLES; outputs level and rise pulse), instantiated once.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-033 A=0x05, B=0x07, clean press held 20 cycles -> pulse in cycle e+7, valid_out high, multiplicando=0x05, multiplicador=0x07, one pulse only.
REQ-034 Bounce 1,0,1,0,1 at 1-cycle intervals, then steady 1 -> exactly one pulse, timed from the last 0->1 transition.
REQ-035 Capture, hold ready_in=0 for 10 cycles, change A to 0xFF -> operands unchanged; ready_in=1 for one cycle -> valid_out low on the next cycle.
REQ-036 Second press while in HOLD -> dropped=1, operands unchanged; pulse coinciding with ready_in=1 -> returns to IDLE and dropped=1.
REQ-037 Reset asserted in HOLD -> all outputs at REQ-028 values on the next cycle; button held through reset -> fresh pulse 7 cycles after reset release.
REQ-038 Sweep A,B over 0..5 every 10 cycles -> LED={A,B} one cycle late; no capture and no pulse occur without a press.

Source files
------------

// File: rtl/captura_operandos_pkg.sv
// Shared definitions for the operand capture block: FSM state encoding
// and the default parameter values used by the top and the debouncer.
package captura_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } estado_t;

  localparam int WIDTH_DEF           = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/captura_operandos_antirrebote.sv
// Button conditioner: multi-flop synchroniser followed by a counting
// debouncer. Produces the debounced level and a one-cycle pulse issued
// the cycle after that level rises.
module antirrebote
  import captura_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic nivel,
  output logic flanco
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   nivel_prev;
  logic                   sincronizado;

  assign sincronizado = sync_q[SYNC_STAGES-1];

  // Shift the raw button through the synchroniser chain to tame metastability.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], boton};
  end

  // Accept a level change once the synchronised input has disagreed for the full count; any agreeing sample restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      nivel <= 1'b0;
    end else if (sincronizado != nivel) begin
      if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        nivel <= sincronizado;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Register a rise detector on the debounced level so the pulse lands the cycle after it goes high.
  always_ff @(posedge clk) begin
    if (reset) begin
      nivel_prev <= 1'b0;
      flanco     <= 1'b0;
    end else begin
      nivel_prev <= nivel;
      flanco     <= nivel & ~nivel_prev;
    end
  end

endmodule

// File: rtl/captura_operandos.sv
// Operand capture front end: a debounced pushbutton latches the A/B
// switch values and offers them downstream with a valid/ready handshake.
// Presses that arrive while a pair is still pending are discarded and
// flagged on a sticky indicator.
module captura_operandos
  import captura_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               pb_entrada,
  input  logic               ready_in,
  output logic [WIDTH-1:0]   multiplicando,
  output logic [WIDTH-1:0]   multiplicador,
  output logic               valid_out,
  output logic               pushbutton_salida,
  output logic [2*WIDTH-1:0] LED,
  output logic               LED_reset,
  output logic               LED_pb,
  output logic               dropped
);

  estado_t estado;
  logic    pulso;

  antirrebote #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_antirrebote (
    .clk   (CLK100MHZ),
    .reset (reset),
    .boton (pb_entrada),
    .nivel (LED_pb),
    .flanco(pulso)
  );

  assign pushbutton_salida = pulso;
  assign LED_reset         = reset;

  // Mirror the switches onto the LEDs one register late.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) LED <= '0;
    else       LED <= {A, B};
  end

  // Capture/handshake FSM: latch on a press in IDLE, hold the pair until accepted, flag presses lost in HOLD.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      estado        <= IDLE;
      multiplicando <= '0;
      multiplicador <= '0;
      valid_out     <= 1'b0;
      dropped       <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (pulso) begin
            multiplicando <= A;
            multiplicador <= B;
            valid_out     <= 1'b1;
            estado        <= HOLD;
          end
        end
        HOLD: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            estado    <= IDLE;
          end
          if (pulso) dropped <= 1'b1;
        end
        default: begin
          valid_out <= 1'b0;
          estado    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_captura_operandos.sv
// Directed bench for captura_operandos with a short debounce window
// (WIDTH=8, DEBOUNCE_CYCLES=4, SYNC_STAGES=2): press latency, bounce
// rejection, handshake, dropped presses, reset in HOLD and LED mirror.
module tb_captura_operandos;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a_sw, b_sw;
  logic           pb, rdy;
  logic [W-1:0]   mcand, mplier;
  logic           valid, pulse, led_reset, led_pb, drop;
  logic [2*W-1:0] led;

  int errors = 0;
  int checks = 0;
  int first_at, pulses, extra;
  logic [2*W-1:0] prev_led;

  captura_operandos #(
    .WIDTH(W), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)
  ) dut (
    .CLK100MHZ        (clk),
    .reset            (rst),
    .A                (a_sw),
    .B                (b_sw),
    .pb_entrada       (pb),
    .ready_in         (rdy),
    .multiplicando    (mcand),
    .multiplicador    (mplier),
    .valid_out        (valid),
    .pushbutton_salida(pulse),
    .LED              (led),
    .LED_reset        (led_reset),
    .LED_pb           (led_pb),
    .dropped          (drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic p, input logic r);
    a_sw = a;
    b_sw = b;
    pb   = p;
    rdy  = r;
  endtask

  // Step n falling edges, recording the index of the first pulse and the pulse count.
  task automatic watch(input int n, output int first, output int count);
    first = 0;
    count = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (pulse === 1'b1) begin
        count++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mcand"},  32'(mcand),  32'h0);
    checkOutput({tag, "_mplier"}, 32'(mplier), 32'h0);
    checkOutput({tag, "_valid"},  32'(valid),  32'h0);
    checkOutput({tag, "_pulse"},  32'(pulse),  32'h0);
    checkOutput({tag, "_led"},    32'(led),    32'h0);
    checkOutput({tag, "_ledpb"},  32'(led_pb), 32'h0);
    checkOutput({tag, "_drop"},   32'(drop),   32'h0);
    checkOutput({tag, "_ledrst"}, 32'(led_reset), 32'h1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkResetValues("rst");
    rst = 1'b0;
    #1 checkOutput("ledrst_low", 32'(led_reset), 32'h0);
    @(negedge clk);
    checkOutput("led_after_rst", 32'(led), 32'h1234);

    // Clean press: pulse on the 8th falling edge (after edge e+7), single pulse
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b0);
    watch(20, first_at, pulses);
    checkOutput("clean_lat",   32'(first_at), 32'd8);
    checkOutput("clean_count", 32'(pulses),   32'd1);
    checkOutput("clean_valid", 32'(valid),    32'h1);
    checkOutput("clean_mcand", 32'(mcand),    32'h05);
    checkOutput("clean_mplier",32'(mplier),   32'h07);
    checkOutput("clean_ledpb", 32'(led_pb),   32'h1);
    pb = 1'b0;
    watch(12, first_at, pulses);
    checkOutput("release_nopulse", 32'(pulses), 32'd0);
    checkOutput("release_ledpb",   32'(led_pb), 32'h0);

    // Hold with ready low, switches change, then a one-cycle handshake
    repeat (10) @(negedge clk);
    a_sw = 8'hFF;
    @(negedge clk);
    checkOutput("hold_mcand",  32'(mcand), 32'h05);
    checkOutput("hold_mplier", 32'(mplier),32'h07);
    checkOutput("hold_valid",  32'(valid), 32'h1);
    checkOutput("hold_led",    32'(led),   32'hFF07);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    checkOutput("hs_valid_low", 32'(valid), 32'h0);

    // Capture, then a press coinciding with the handshake
    applyStimulus(8'h11, 8'h22, 1'b1, 1'b0);
    watch(20, first_at, pulses);
    checkOutput("cap2_lat",   32'(first_at), 32'd8);
    checkOutput("cap2_mcand", 32'(mcand),    32'h11);
    checkOutput("cap2_drop",  32'(drop),     32'h0);
    pb = 1'b0;
    watch(12, first_at, pulses);
    applyStimulus(8'h33, 8'h44, 1'b1, 1'b0);
    watch(8, first_at, pulses);
    checkOutput("coinc_pulse", 32'(pulse), 32'h1);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    checkOutput("coinc_valid",  32'(valid),  32'h0);
    checkOutput("coinc_drop",   32'(drop),   32'h1);
    checkOutput("coinc_mcand",  32'(mcand),  32'h11);
    checkOutput("coinc_mplier", 32'(mplier), 32'h22);
    pb = 1'b0;
    watch(12, first_at, pulses);
    checkOutput("coinc_idle_valid", 32'(valid), 32'h0);

    // Reset asserted in HOLD with the button held through it
    applyStimulus(8'h44, 8'h55, 1'b1, 1'b0);
    watch(20, first_at, pulses);
    checkOutput("pre_rst_valid", 32'(valid), 32'h1);
    checkOutput("pre_rst_mcand", 32'(mcand), 32'h44);
    rst = 1'b1;
    a_sw = 8'h66;
    b_sw = 8'h77;
    @(negedge clk);
    checkResetValues("hold_rst");
    @(negedge clk);
    rst = 1'b0;
    watch(20, first_at, pulses);
    checkOutput("postrst_lat",    32'(first_at), 32'd8);
    checkOutput("postrst_count",  32'(pulses),   32'd1);
    checkOutput("postrst_mcand",  32'(mcand),    32'h66);
    checkOutput("postrst_mplier", 32'(mplier),   32'h77);
    checkOutput("postrst_drop",   32'(drop),     32'h0);

    // Second press while HOLD is pending
    pb = 1'b0;
    watch(12, first_at, pulses);
    a_sw = 8'h99;
    pb   = 1'b1;
    watch(20, first_at, pulses);
    checkOutput("drop_count", 32'(pulses), 32'd1);
    checkOutput("drop_flag",  32'(drop),   32'h1);
    checkOutput("drop_mcand", 32'(mcand),  32'h66);
    checkOutput("drop_valid", 32'(valid),  32'h1);
    pb = 1'b0;
    watch(12, first_at, pulses);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    checkOutput("drop_hs_valid", 32'(valid), 32'h0);

    // Bounce 1,0,1,0 then the final 1 held steady
    applyStimulus(8'h0A, 8'h0B, 1'b0, 1'b0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      pb = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (pulse === 1'b1) extra++;
    end
    pb = 1'b1;
    watch(20, first_at, pulses);
    checkOutput("bounce_lat",   32'(first_at),      32'd8);
    checkOutput("bounce_count", 32'(pulses + extra), 32'd1);
    checkOutput("bounce_mcand", 32'(mcand),          32'h0A);
    pb = 1'b0;
    watch(12, first_at, pulses);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;

    // Switch sweep without presses: LED trails {A,B} by one cycle
    extra = 0;
    for (int i = 0; i <= 5; i++) begin
      prev_led = {a_sw, b_sw};
      a_sw = 8'(i);
      b_sw = 8'(5 - i);
      #1 checkOutput("sweep_led_late", 32'(led), 32'(prev_led));
      @(negedge clk);
      checkOutput("sweep_led", 32'(led), 32'({a_sw, b_sw}));
      watch(9, first_at, pulses);
      extra += pulses;
    end
    checkOutput("sweep_nopulse", 32'(extra), 32'd0);
    checkOutput("sweep_valid",   32'(valid), 32'h0);
    checkOutput("sweep_mcand",   32'(mcand), 32'h0A);
    checkOutput("sweep_mplier",  32'(mplier),32'h0B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
